// File: rtl/apb_pkg.sv
// Shared types for the APB initiator: FSM state encoding and the
// response record carried back to the requester.
package apb_pkg;

    localparam int APB_PDATA_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic [APB_PDATA_SIZE-1:0] rdata;
        logic                      err;
        logic                      timeout;
    } apb_rsp_t;

    // Build a response record in one expression.
    function automatic apb_rsp_t make_rsp(
        input logic [APB_PDATA_SIZE-1:0] rdata,
        input logic                      err,
        input logic                      timeout
    );
        apb_rsp_t r;
        r.rdata   = rdata;
        r.err     = err;
        r.timeout = timeout;
        return r;
    endfunction

endpackage

// File: rtl/apb_initiator.sv
// Single-outstanding APB3 master. Turns a valid/ready request stream into
// SETUP/ACCESS phases, returns one response at a time and aborts transfers
// whose slave keeps PREADY low for too long.
//
// The response slot holds one entry. A transfer is only allowed into ACCESS
// while the slot is free, so by the time it completes (or times out) the slot
// is guaranteed empty and APB never has to be stalled waiting on rsp_ready.
module apb_initiator
    import apb_pkg::*;
#(
    parameter int PADDR_SIZE = 12,
    parameter int PDATA_SIZE = APB_PDATA_SIZE,
    parameter int TIMEOUT    = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [PADDR_SIZE-1:0] req_addr,
    input  logic [PDATA_SIZE-1:0] req_wdata,
    input  logic                  req_write,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [PDATA_SIZE-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [PADDR_SIZE-1:0] PADDR,
    output logic [PDATA_SIZE-1:0] PWDATA,
    output logic                  PWRITE,
    input  logic [PDATA_SIZE-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // A zero TIMEOUT disables the watchdog; keep the counter one bit wide then.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_t       state;
    logic [CNT_W-1:0] wd_count;
    apb_rsp_t         rsp_q;
    logic             rsp_valid_q;

    logic slot_free;
    logic accept;
    logic complete;
    logic abort;

    assign slot_free = !rsp_valid_q || rsp_ready;
    assign req_ready = !PRESET && slot_free &&
                       ((state == IDLE) || ((state == ACCESS) && PREADY));
    assign accept    = req_valid && req_ready;
    assign complete  = (state == ACCESS) && PREADY;
    assign abort     = (TIMEOUT > 0) && (state == ACCESS) && !PREADY &&
                       (wd_count == CNT_W'(TIMEOUT - 1));

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = PDATA_SIZE'(rsp_q.rdata);
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

    // Bus FSM: drives PSEL/PENABLE, latches the request and runs the watchdog.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            PADDR    <= '0;
            PWDATA   <= '0;
            PWRITE   <= 1'b0;
            wd_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= SETUP;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        PADDR   <= req_addr;
                        PWDATA  <= req_wdata;
                        PWRITE  <= req_write;
                    end
                end
                SETUP: begin
                    // Waiting here while the slot is full keeps completion
                    // from ever colliding with an unconsumed response.
                    if (slot_free) begin
                        state    <= ACCESS;
                        PENABLE  <= 1'b1;
                        wd_count <= '0;
                    end
                end
                ACCESS: begin
                    if (complete) begin
                        if (accept) begin
                            state   <= SETUP;
                            PSEL    <= 1'b1;
                            PENABLE <= 1'b0;
                            PADDR   <= req_addr;
                            PWDATA  <= req_wdata;
                            PWRITE  <= req_write;
                        end else begin
                            state   <= IDLE;
                            PSEL    <= 1'b0;
                            PENABLE <= 1'b0;
                        end
                    end else if (abort) begin
                        state   <= IDLE;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                    end else begin
                        wd_count <= wd_count + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                end
            endcase
        end
    end

    // Response slot: filled by completion or watchdog abort, emptied on handshake.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else if (complete) begin
            rsp_valid_q <= 1'b1;
            rsp_q       <= make_rsp(PWRITE ? '0 : APB_PDATA_SIZE'(PRDATA), PSLVERR, 1'b0);
        end else if (abort) begin
            rsp_valid_q <= 1'b1;
            rsp_q       <= make_rsp('0, 1'b1, 1'b1);
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

endmodule
